// File: rtl/uart_core.sv
// uart_core: 8N1 UART transmitter with receive-and-echo loopback path.
// Define UART_PARITY_EN to add an even-parity bit on both TX paths.

module uart_core_tx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_tx
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_clk, w_clk;
    logic [2:0]  r_idx, w_idx;
    logic [7:0]  r_data, w_data;
    logic        r_tx, w_tx;
    logic        w_last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_clk   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_clk   <= w_clk;
            r_idx   <= w_idx;
            r_data  <= w_data;
            r_tx    <= w_tx;
        end
    end

    assign o_tx = r_tx;

    always_comb begin
        w_state = r_state;
        w_clk   = r_clk;
        w_idx   = r_idx;
        w_data  = r_data;
        w_last  = (r_clk == LAST);
        if (r_state != S_IDLE)
            w_clk = w_last ? 16'd0 : r_clk + 16'd1;
        unique case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_state = S_START;
                    w_data  = i_data;
                    w_idx   = 3'd0;
                end
            end
            S_START: begin
                if (w_last)
                    w_state = S_DATA;
            end
            S_DATA: begin
                if (w_last) begin
                    w_idx = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state = S_PAR;
`else
                        w_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PAR: begin
                if (w_last)
                    w_state = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_last)
                    w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        // Line value follows the next state so the bit leaves with the edge.
        w_tx = 1'b1;
        case (w_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = w_data[w_idx];
`ifdef UART_PARITY_EN
            S_PAR:   w_tx = ^w_data;
`endif
            default: w_tx = 1'b1;
        endcase
    end
endmodule

module uart_core #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       dout,
    output logic       final_dout
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PAR,
        R_STOP,
        R_WAIT
    } rx_state_t;

    logic        r_start_d;
    logic        w_start_rise;
    rx_state_t   r_rx_state, w_rx_state;
    logic [15:0] r_rx_clk, w_rx_clk;
    logic [2:0]  r_rx_idx, w_rx_idx;
    logic [7:0]  r_rx_data, w_rx_data;
    logic        r_line_d;
    logic        w_rx_last;
    logic        w_rx_done;
`ifdef UART_PARITY_EN
    logic        r_rx_perr, w_rx_perr;
`endif

    assign w_start_rise = start & ~r_start_d;

    uart_core_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_load (w_start_rise),
        .i_data (din),
        .o_tx   (dout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_start_d  <= 1'b0;
            r_line_d   <= 1'b1;
            r_rx_state <= R_IDLE;
            r_rx_clk   <= '0;
            r_rx_idx   <= '0;
            r_rx_data  <= '0;
`ifdef UART_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
        end else begin
            r_start_d  <= start;
            r_line_d   <= dout;
            r_rx_state <= w_rx_state;
            r_rx_clk   <= w_rx_clk;
            r_rx_idx   <= w_rx_idx;
            r_rx_data  <= w_rx_data;
`ifdef UART_PARITY_EN
            r_rx_perr  <= w_rx_perr;
`endif
        end
    end

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_clk   = r_rx_clk;
        w_rx_idx   = r_rx_idx;
        w_rx_data  = r_rx_data;
        w_rx_done  = 1'b0;
        w_rx_last  = (r_rx_clk == LAST);
`ifdef UART_PARITY_EN
        w_rx_perr  = r_rx_perr;
`endif
        unique case (r_rx_state)
            R_IDLE: begin
                // The detecting cycle is offset 0 of the start bit.
                if (r_line_d && !dout) begin
                    w_rx_idx = 3'd0;
                    if (HALF == 16'd0) begin
                        w_rx_state = R_DATA;
                        w_rx_clk   = 16'd0;
                    end else begin
                        w_rx_state = R_START;
                        w_rx_clk   = 16'd1;
                    end
                end
            end
            R_START: begin
                if (r_rx_clk == HALF) begin
                    w_rx_clk   = 16'd0;
                    w_rx_state = dout ? R_IDLE : R_DATA;
                end else begin
                    w_rx_clk = r_rx_clk + 16'd1;
                end
            end
            R_DATA: begin
                if (w_rx_last) begin
                    w_rx_clk  = 16'd0;
                    w_rx_data = {dout, r_rx_data[7:1]};
                    w_rx_idx  = r_rx_idx + 3'd1;
                    if (r_rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_rx_state = R_PAR;
`else
                        w_rx_state = R_STOP;
`endif
                    end
                end else begin
                    w_rx_clk = r_rx_clk + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            R_PAR: begin
                if (w_rx_last) begin
                    w_rx_clk   = 16'd0;
                    w_rx_perr  = dout ^ (^r_rx_data);
                    w_rx_state = R_STOP;
                end else begin
                    w_rx_clk = r_rx_clk + 16'd1;
                end
            end
`endif
            R_STOP: begin
                if (w_rx_last) begin
                    w_rx_clk = 16'd0;
                    if (dout) begin
                        w_rx_state = R_IDLE;
`ifdef UART_PARITY_EN
                        w_rx_done  = ~r_rx_perr;
`else
                        w_rx_done  = 1'b1;
`endif
                    end else begin
                        w_rx_state = R_WAIT;
                    end
                end else begin
                    w_rx_clk = r_rx_clk + 16'd1;
                end
            end
            R_WAIT: begin
                if (dout)
                    w_rx_state = R_IDLE;
            end
            default: w_rx_state = R_IDLE;
        endcase
    end

    uart_core_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_echo (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_load (w_rx_done),
        .i_data (r_rx_data),
        .o_tx   (final_dout)
    );
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core frames, echo, busy drop and reset.
`timescale 1ns/1ps

module tb_uart_core;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       start1, start4;
    logic [7:0] din1, din4;
    logic       dout1, fd1, dout4, fd4;

    int n_chk = 0;
    int n_err = 0;

`ifdef UART_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    always #5 clk = ~clk;

    uart_core #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start1),
        .din        (din1),
        .dout       (dout1),
        .final_dout (fd1)
    );

    uart_core #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start4),
        .din        (din4),
        .dout       (dout4),
        .final_dout (fd4)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return b[k-1];
        if (FL == 11 && k == 9)
            return ^b;
        return 1'b1;
    endfunction

    // Echo lags by (FL-1) bits to the stop sample, plus the mid-bit offset, plus one.
    task automatic run_frame(input int sel, input logic [7:0] b,
                             input int hold, input int second_at,
                             input logic [7:0] b2, input int len);
        int   cpb;
        int   d;
        logic od, of, st;
        cpb = (sel == 1) ? 1 : 4;
        d = (FL - 1) * cpb + cpb / 2 + 1;
        if (sel == 1) begin
            din1 = b;
            start1 = 1'b1;
        end else begin
            din4 = b;
            start4 = 1'b1;
        end
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            od = (sel == 1) ? dout1 : dout4;
            of = (sel == 1) ? fd1 : fd4;
            chk($sformatf("dout%0d_%02h_c%0d", sel, b, c), od,
                (c < FL * cpb) ? fbit(b, c / cpb) : 1'b1);
            chk($sformatf("final%0d_%02h_c%0d", sel, b, c), of,
                (c >= d && c - d < FL * cpb) ? fbit(b, (c - d) / cpb) : 1'b1);
            st = (c + 1 < hold) || (c + 1 >= second_at && c + 1 < second_at + 4);
            if (sel == 1) begin
                start1 = st;
                if (c + 1 >= second_at)
                    din1 = b2;
            end else begin
                start4 = st;
                if (c + 1 >= second_at)
                    din4 = b2;
            end
        end
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    initial begin
        n_rst = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        din1 = 8'h00;
        din4 = 8'h00;
        #1;
        n_rst = 1'b0;
        start1 = 1'b1;
        start4 = 1'b1;
        din1 = 8'hFF;
        din4 = 8'hFF;
        #12;
        chk("rst_dout1", dout1, 1'b1);
        chk("rst_final1", fd1, 1'b1);
        chk("rst_dout4", dout4, 1'b1);
        chk("rst_final4", fd4, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_dout1_%0d", i), dout1, 1'b1);
            chk($sformatf("rst_hold_dout4_%0d", i), dout4, 1'b1);
        end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_dout1", dout1, 1'b1);

        run_frame(1, 8'h81, 5, 1000, 8'h00, 24);
        run_frame(1, 8'h81, 3, 4, 8'h3C, 24);
        run_frame(4, 8'hA5, 1, 1000, 8'h00, 84);

        din1 = 8'h55;
        start1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("mid_dout_c%0d", c), dout1, fbit(8'h55, c));
            start1 = 1'b0;
        end
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_dout", dout1, 1'b1);
        chk("mid_rst_final", fd1, 1'b1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_dout", dout1, 1'b1);
        run_frame(1, 8'h55, 2, 1000, 8'h00, 24);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
